// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with a two-state wait sequencer for multi-cycle data-memory accesses.
// Holds the pending instruction across a miss and keeps sticky halt/error flags and a stall counter.
module mem_wb_reg #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validIn,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic [15:0]      aluOut,
    input  logic [15:0]      memoryOut,
    input  logic             Done,
    input  logic             Stall,
    input  logic             memErr,
    input  logic [2:0]       wbRegIn,
    input  logic             regWriteIn,
    input  logic             memToRegIn,
    input  logic             haltIn,
    output logic             pipeStall,
    output logic             validOut,
    output logic [15:0]      wbData,
    output logic [2:0]       wbReg,
    output logic             regWrite,
    output logic             halt,
    output logic             err,
    output logic [CNT_W-1:0] stallCount
);

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic             regwrite_q, regwrite_d;
    logic [15:0]      wb_data_q, wb_data_d;
    logic [2:0]       wb_reg_q, wb_reg_d;
    logic             halt_q, halt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Holding registers for the instruction parked in the wait state
    logic [15:0]      hold_alu_q, hold_alu_d;
    logic [2:0]       hold_reg_q, hold_reg_d;
    logic             hold_rw_q, hold_rw_d;
    logic             hold_m2r_q, hold_m2r_d;
    logic             hold_halt_q, hold_halt_d;

    logic             in_idle;
    logic             acc;
    logic             cap_in;
    logic             cap_hold;
    logic             capture;
    logic             miss_start;
    logic [15:0]      sel_alu;
    logic [2:0]       sel_reg;
    logic             sel_rw;
    logic             sel_m2r;
    logic             sel_halt;
    logic             unused_stall;

    // Busy is informational; sequencing relies on Done alone
    assign unused_stall = Stall;

    always_comb begin
        in_idle    = (state_q == StIdle);
        acc        = validIn & (memRead | memWrite) & ~halt_q;
        miss_start = in_idle & acc & ~Done;
        // Hit or ALU-path instruction completes straight from the inputs
        cap_in     = in_idle & validIn & ~halt_q & (~acc | Done);
        cap_hold   = ~in_idle & Done;
        capture    = cap_in | cap_hold;
    end

    always_comb begin
        if (in_idle) begin
            sel_alu  = aluOut;
            sel_reg  = wbRegIn;
            sel_rw   = regWriteIn;
            sel_m2r  = memToRegIn;
            sel_halt = haltIn;
        end else begin
            sel_alu  = hold_alu_q;
            sel_reg  = hold_reg_q;
            sel_rw   = hold_rw_q;
            sel_m2r  = hold_m2r_q;
            sel_halt = hold_halt_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = capture;
        regwrite_d  = capture & sel_rw;
        wb_data_d   = wb_data_q;
        wb_reg_d    = wb_reg_q;
        halt_d      = halt_q | (capture & sel_halt);
        err_d       = err_q | (memErr & ((in_idle & acc) | ~in_idle));
        cnt_d       = cnt_q;
        hold_alu_d  = hold_alu_q;
        hold_reg_d  = hold_reg_q;
        hold_rw_d   = hold_rw_q;
        hold_m2r_d  = hold_m2r_q;
        hold_halt_d = hold_halt_q;

        if (capture) begin
            wb_data_d = sel_m2r ? memoryOut : sel_alu;
            wb_reg_d  = sel_reg;
        end

        if (miss_start) begin
            state_d     = StWait;
            hold_alu_d  = aluOut;
            hold_reg_d  = wbRegIn;
            hold_rw_d   = regWriteIn;
            hold_m2r_d  = memToRegIn;
            hold_halt_d = haltIn;
        end

        if (!in_idle) begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CntOne;
            end
            if (Done) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_reg_q    <= '0;
            halt_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            hold_alu_q  <= '0;
            hold_reg_q  <= '0;
            hold_rw_q   <= 1'b0;
            hold_m2r_q  <= 1'b0;
            hold_halt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            wb_data_q   <= wb_data_d;
            wb_reg_q    <= wb_reg_d;
            halt_q      <= halt_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            hold_alu_q  <= hold_alu_d;
            hold_reg_q  <= hold_reg_d;
            hold_rw_q   <= hold_rw_d;
            hold_m2r_q  <= hold_m2r_d;
            hold_halt_q <= hold_halt_d;
        end
    end

    always_comb begin
        pipeStall  = ~rst & (miss_start | (~in_idle & ~Done));
        validOut   = valid_q;
        regWrite   = regwrite_q;
        wbData     = wb_data_q;
        wbReg      = wb_reg_q;
        halt       = halt_q;
        err        = err_q;
        stallCount = cnt_q;
    end

endmodule

// File: tb/tb_mem_wb_reg.sv
// Bench for mem_wb_reg: vector table with a scoreboard queue of expected write-back results,
// plus hand-built sequences for reset mid-wait and stall-counter saturation.
module tb_mem_wb_reg;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          validIn, memRead, memWrite, Done, Stall, memErr;
    logic [15:0]   aluOut, memoryOut;
    logic [2:0]    wbRegIn;
    logic          regWriteIn, memToRegIn, haltIn;
    logic          pipeStall, validOut, regWrite, halt, err;
    logic [15:0]   wbData;
    logic [2:0]    wbReg;
    logic [CW-1:0] stallCount;

    int n_pass  = 0;
    int n_total = 0;

    mem_wb_reg #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .validIn    (validIn),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .aluOut     (aluOut),
        .memoryOut  (memoryOut),
        .Done       (Done),
        .Stall      (Stall),
        .memErr     (memErr),
        .wbRegIn    (wbRegIn),
        .regWriteIn (regWriteIn),
        .memToRegIn (memToRegIn),
        .haltIn     (haltIn),
        .pipeStall  (pipeStall),
        .validOut   (validOut),
        .wbData     (wbData),
        .wbReg      (wbReg),
        .regWrite   (regWrite),
        .halt       (halt),
        .err        (err),
        .stallCount (stallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic          rw;
        logic [15:0]   data;
        logic [2:0]    wreg;
        logic          hlt;
        logic          er;
        logic [CW-1:0] cnt;
    } out_t;

    typedef struct {
        logic        vi, rd, wr, dn, me, hl, rw, m2r;
        logic [2:0]  wreg;
        logic [15:0] alu, mem;
        logic        stall;
        out_t        exp;
    } vec_t;

    out_t sb_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(input logic vi, rd, wr, dn, me, hl, rw, m2r,
                                input logic [2:0] wreg, input logic [15:0] alu, mem,
                                input logic st, ev, erw, input logic [15:0] ed,
                                input logic [2:0] ewr, input logic eh, ee,
                                input logic [CW-1:0] ec);
        vec_t r;
        r.vi = vi; r.rd = rd; r.wr = wr; r.dn = dn; r.me = me; r.hl = hl;
        r.rw = rw; r.m2r = m2r; r.wreg = wreg; r.alu = alu; r.mem = mem;
        r.stall = st;
        r.exp.valid = ev; r.exp.rw = erw; r.exp.data = ed; r.exp.wreg = ewr;
        r.exp.hlt = eh; r.exp.er = ee; r.exp.cnt = ec;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic clear_inputs();
        validIn = 0; memRead = 0; memWrite = 0; Done = 0; Stall = 0; memErr = 0;
        aluOut = 0; memoryOut = 0; wbRegIn = 0; regWriteIn = 0; memToRegIn = 0; haltIn = 0;
    endtask

    task automatic drive(input vec_t r);
        validIn = r.vi; memRead = r.rd; memWrite = r.wr; Done = r.dn; memErr = r.me;
        haltIn = r.hl; regWriteIn = r.rw; memToRegIn = r.m2r; wbRegIn = r.wreg;
        aluOut = r.alu; memoryOut = r.mem;
        Stall = r.vi & (r.rd | r.wr) & ~r.dn;
    endtask

    task automatic compare_out(input string tag);
        out_t e;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL %s_sb: got empty scoreboard, expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_validOut"},   32'(validOut),   32'(e.valid));
            chk({tag, "_regWrite"},   32'(regWrite),   32'(e.rw));
            chk({tag, "_wbData"},     32'(wbData),     32'(e.data));
            chk({tag, "_wbReg"},      32'(wbReg),      32'(e.wreg));
            chk({tag, "_halt"},       32'(halt),       32'(e.hlt));
            chk({tag, "_err"},        32'(err),        32'(e.er));
            chk({tag, "_stallCount"}, 32'(stallCount), 32'(e.cnt));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        #1;
        chk("rst_validOut",   32'(validOut),   0);
        chk("rst_regWrite",   32'(regWrite),   0);
        chk("rst_wbData",     32'(wbData),     0);
        chk("rst_wbReg",      32'(wbReg),      0);
        chk("rst_halt",       32'(halt),       0);
        chk("rst_err",        32'(err),        0);
        chk("rst_stallCount", 32'(stallCount), 0);
        chk("rst_pipeStall",  32'(pipeStall),  0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        //       vi rd wr dn me hl rw m2r reg alu      mem      | st ev erw data     reg eh ee cnt
        tbl.push_back(mk(1,0,0,0,0,0,1,0, 3, 16'h1234, 16'h0000, 0,1,1, 16'h1234, 3, 0,0, 0));
        tbl.push_back(mk(0,0,0,1,0,0,0,0, 0, 16'h0000, 16'hFFFF, 0,0,0, 16'h1234, 3, 0,0, 0));
        tbl.push_back(mk(1,1,0,1,0,0,1,1, 5, 16'h0040, 16'hBEEF, 0,1,1, 16'hBEEF, 5, 0,0, 0));
        tbl.push_back(mk(1,1,0,0,0,0,1,1, 6, 16'h0100, 16'h0000, 1,0,0, 16'hBEEF, 5, 0,0, 0));
        tbl.push_back(mk(1,0,1,0,0,0,0,0, 2, 16'h9999, 16'h0000, 1,0,0, 16'hBEEF, 5, 0,0, 1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0, 16'h0000, 16'h0000, 1,0,0, 16'hBEEF, 5, 0,0, 2));
        tbl.push_back(mk(1,0,0,1,0,0,0,0, 7, 16'h8888, 16'hCAFE, 0,1,1, 16'hCAFE, 6, 0,0, 3));
        tbl.push_back(mk(1,0,1,0,0,0,0,0, 1, 16'h0200, 16'h0000, 1,0,0, 16'hCAFE, 6, 0,0, 3));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0, 16'h0000, 16'h0000, 1,0,0, 16'hCAFE, 6, 0,0, 4));
        tbl.push_back(mk(0,0,0,1,0,0,0,0, 0, 16'h0000, 16'h1111, 0,1,0, 16'h0200, 1, 0,0, 5));
        tbl.push_back(mk(1,1,1,1,0,0,1,1, 4, 16'h0300, 16'hABCD, 0,1,1, 16'hABCD, 4, 0,0, 5));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 2, 16'h5555, 16'h0000, 0,1,0, 16'h5555, 2, 0,0, 5));
        tbl.push_back(mk(1,1,0,1,1,0,1,1, 3, 16'h0400, 16'h0F0F, 0,1,1, 16'h0F0F, 3, 0,1, 5));
        tbl.push_back(mk(0,0,0,0,1,0,0,0, 0, 16'h0000, 16'h0000, 0,0,0, 16'h0F0F, 3, 0,1, 5));
        tbl.push_back(mk(1,0,0,0,0,1,0,0, 0, 16'h0000, 16'h0000, 0,1,0, 16'h0000, 0, 1,1, 5));
        tbl.push_back(mk(1,1,0,0,0,0,1,0, 7, 16'h7777, 16'h0000, 0,0,0, 16'h0000, 0, 1,1, 5));
        tbl.push_back(mk(1,0,0,0,0,0,1,0, 6, 16'h6666, 16'h0000, 0,0,0, 16'h0000, 0, 1,1, 5));

        for (int i = 0; i < tbl.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_pipeStall", i), 32'(pipeStall), 32'(tbl[i].stall));
            sb_q.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            compare_out($sformatf("v%0d", i));
        end

        // Error during a miss, then reset abandons the pending access
        do_reset();
        @(negedge clk);
        validIn = 1; memRead = 1; wbRegIn = 5; aluOut = 16'h0011; memToRegIn = 1; regWriteIn = 1;
        #1 chk("rw_stall0", 32'(pipeStall), 1);
        @(posedge clk);
        @(negedge clk);
        validIn = 0; memRead = 0; memErr = 1;
        #1 chk("rw_stall1", 32'(pipeStall), 1);
        @(posedge clk);
        #1;
        chk("rw_err_set",   32'(err),        1);
        chk("rw_valid_low", 32'(validOut),   0);
        chk("rw_cnt1",      32'(stallCount), 1);
        @(negedge clk);
        memErr = 0;
        #2 rst = 1;
        #1;
        chk("rw_rst_validOut",   32'(validOut),   0);
        chk("rw_rst_regWrite",   32'(regWrite),   0);
        chk("rw_rst_wbData",     32'(wbData),     0);
        chk("rw_rst_wbReg",      32'(wbReg),      0);
        chk("rw_rst_halt",       32'(halt),       0);
        chk("rw_rst_err",        32'(err),        0);
        chk("rw_rst_stallCount", 32'(stallCount), 0);
        chk("rw_rst_pipeStall",  32'(pipeStall),  0);
        Done = 1; memoryOut = 16'hDEAD;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1 chk("rw_post_stall", 32'(pipeStall), 0);
        @(posedge clk);
        #1;
        chk("rw_post_validOut", 32'(validOut), 0);
        chk("rw_post_wbData",   32'(wbData),   0);

        // Long miss saturates the counter; parked halt flag lands on capture
        do_reset();
        @(negedge clk);
        validIn = 1; memRead = 1; haltIn = 1; wbRegIn = 2; aluOut = 16'h0022;
        memToRegIn = 1; regWriteIn = 1;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            clear_inputs();
            #1 chk($sformatf("sat_stall%0d", k), 32'(pipeStall), 1);
            @(posedge clk);
        end
        #1 chk("sat_cnt", 32'(stallCount), 7);
        @(negedge clk);
        Done = 1; memoryOut = 16'h0BAD;
        @(posedge clk);
        #1;
        chk("sat_validOut", 32'(validOut),   1);
        chk("sat_wbData",   32'(wbData),     16'h0BAD);
        chk("sat_wbReg",    32'(wbReg),      2);
        chk("sat_regWrite", 32'(regWrite),   1);
        chk("sat_halt",     32'(halt),       1);
        chk("sat_cnt_hold", 32'(stallCount), 7);
        @(negedge clk);
        clear_inputs();
        validIn = 1; memRead = 1;
        #1 chk("sat_halted_stall", 32'(pipeStall), 0);
        @(posedge clk);
        #1 chk("sat_halted_valid", 32'(validOut), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_wb_reg.md
MEM_WB_REG -- requirements
Module: mem_wb_reg

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 validIn  input  1  instruction present in memory stage this cycle.
REQ-005 memRead  input  1  instruction reads data memory.
REQ-006 memWrite  input  1  instruction writes data memory.
REQ-007 aluOut  input  16  ALU result, also the memory address.
REQ-008 memoryOut  input  16  data-memory read data.
REQ-009 Done  input  1  data memory reports access complete; memoryOut valid this cycle.
REQ-010 Stall  input  1  data memory busy; informational only, excluded from sequencing.
REQ-011 memErr  input  1  data-memory error flag.
REQ-012 wbRegIn  input  3  destination register number.
REQ-013 regWriteIn  input  1  instruction writes the register file.
REQ-014 memToRegIn  input  1  write-back source is memory, not ALU.
REQ-015 haltIn  input  1  instruction is HALT.
REQ-016 pipeStall  output  1  freeze upstream stages; combinational.
REQ-017 validOut  output  1  write-back slot holds a real instruction.
REQ-018 wbData  output  16  write-back data.
REQ-019 wbReg  output  3  write-back register number.
REQ-020 regWrite  output  1  register-file write enable; equals regWriteIn of the captured instruction AND validOut.
REQ-021 halt  output  1  sticky halted indication.
REQ-022 err  output  1  sticky error indication.
REQ-023 stallCount  output  CNT_W  total WAIT-state cycles since reset.

Function
REQ-024 Access condition: acc = validIn & (memRead | memWrite) & !halt.
REQ-025 FSM states: IDLE and WAIT; reset state IDLE.
REQ-026 IDLE, acc & Done: capture at the clock edge; remain in IDLE (single-cycle hit).
REQ-027 IDLE, acc & !Done: latch aluOut, wbRegIn, regWriteIn, memToRegIn and haltIn into holding registers; go to WAIT.
REQ-028 IDLE, validIn & !acc & !halt: capture ALU-path instruction at the clock edge.
REQ-029 WAIT: inputs other than Done, memoryOut and memErr are ignored; use the holding registers.
REQ-030 WAIT & Done: capture from the holding registers and memoryOut; go to IDLE.
REQ-031 pipeStall = (IDLE & acc & !Done) | (WAIT & !Done).
REQ-032 Capture: validOut<=1; wbReg, regWrite and halt contributions come from the captured instruction.
REQ-033 Capture, wbData source: memoryOut if memToReg=1, else aluOut.
REQ-034 Store instructions (memWrite, regWrite=0) capture with regWrite=0 and validOut=1.
REQ-035 No-capture cycles: validOut<=0 and regWrite<=0 (bubble); wbData and wbReg hold their previous values.
REQ-036 Output latency: exactly one cycle after the Done cycle, or after the validIn cycle for the ALU path.
REQ-037 halt: set on capture of an instruction with halt flag set; sticky.
REQ-038 While halt=1: no further capture, acc=0, and pipeStall=0.
REQ-039 err: set when memErr=1 in any cycle with IDLE & acc or in WAIT; sticky.
REQ-040 stallCount: increments by 1 every cycle state=WAIT; saturates at all-ones, no wrap.
REQ-041 Done in IDLE without acc is ignored.
REQ-042 memRead & memWrite both set is treated as a single access; regWrite follows regWriteIn.

Reset
REQ-043 rst=1 immediately forces: state=IDLE, validOut=0, regWrite=0, wbData=0, wbReg=0, halt=0, err=0, stallCount=0.
REQ-044 The same forced values apply to all holding registers.
REQ-045 Reset asserted during WAIT abandons the access with no capture.
REQ-046 pipeStall=0 while rst=1.

Verification
REQ-047 ALU op: validIn=1, aluOut=0x1234, memToRegIn=0, regWriteIn=1, wbRegIn=3 -> next cycle validOut=1, wbData=0x1234, wbReg=3, regWrite=1, pipeStall never 1.
REQ-048 Load hit: memRead=1, Done=1 same cycle, memoryOut=0xBEEF, memToRegIn=1 -> next cycle wbData=0xBEEF, state stays IDLE, stallCount=0.
REQ-049 Load miss, Done after 3 cycles:
- pipeStall=1 for 3 cycles and validOut=0 during them.
- Inputs changing in WAIT are ignored.
- Capture uses the latched wbReg; stallCount=3.
REQ-050 Store miss: memWrite=1, Done after 2 cycles -> validOut=1 with regWrite=0; stallCount=2.
REQ-051 HALT captured -> halt=1 sticky; later validIn=1 with Done=0 yields validOut=0 and pipeStall=0.
REQ-052 memErr pulse in WAIT, then rst asserted mid-WAIT -> err=1 before reset; all outputs 0 immediately under rst; no capture occurs.
